// File: rtl/motor_arm_sequencer_pkg.sv
// motor_arm_sequencer_pkg: state encodings and width defaults shared by the arm sequencer files.
package motor_arm_sequencer_pkg;
    localparam int MOTOR_RATE_BIT_WIDTH = 8;
    localparam int NUM_MOTORS = 4;
    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMING   = 2'b01,
        ST_ARMED    = 2'b10,
        ST_FAILSAFE = 2'b11
    } arm_state_t;
endpackage

// File: rtl/motor_arm_sequencer_ms_tick_gen.sv
// motor_arm_sequencer_ms_tick_gen: free-running divider, o_tick high for one cycle every TICK_DIV cycles.
module motor_arm_sequencer_ms_tick_gen #(
    parameter int TICK_DIV = 38000
) (
    input  logic sys_clk,
    input  logic resetn,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge sys_clk)
        if (!resetn) r_cnt <= '0;
        else r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    assign o_tick = r_cnt == LAST;
endmodule

// File: rtl/motor_arm_sequencer.sv
// motor_arm_sequencer: safety gate forcing motor rates to 0 unless ARMED, with rx-loss/IMU failsafe.
// Build option MOTOR_ARM_SLEW_LIMIT_EN ramps each rate up by at most SLEW_STEP per ms tick while ARMED.
module motor_arm_sequencer
    import motor_arm_sequencer_pkg::*;
#(
    parameter int RATE_W        = MOTOR_RATE_BIT_WIDTH,
    parameter int TICK_DIV      = 38000,
    parameter int ARM_HOLD_MS   = 1000,
    parameter int RX_TIMEOUT_MS = 100,
    parameter int THR_LOW_MAX   = 10,
    parameter int SLEW_STEP     = 4
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic [RATE_W-1:0] motor_1_rate_in,
    input  logic [RATE_W-1:0] motor_2_rate_in,
    input  logic [RATE_W-1:0] motor_3_rate_in,
    input  logic [RATE_W-1:0] motor_4_rate_in,
    input  logic [7:0]        throttle_val,
    input  logic              arm_switch,
    input  logic              imu_good,
    input  logic              rx_update,
    output logic [RATE_W-1:0] motor_1_rate_out,
    output logic [RATE_W-1:0] motor_2_rate_out,
    output logic [RATE_W-1:0] motor_3_rate_out,
    output logic [RATE_W-1:0] motor_4_rate_out,
    output logic              armed,
    output logic [1:0]        state_out,
    output logic [1:0]        fault_flags
);
`ifdef MOTOR_ARM_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif
    localparam int HW = $clog2(ARM_HOLD_MS + 1);
    localparam int WW = $clog2(RX_TIMEOUT_MS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(ARM_HOLD_MS - 1);
    localparam logic [WW-1:0] WD_MAX = WW'(RX_TIMEOUT_MS);
    localparam logic [WW-1:0] WD_LAST = WW'(RX_TIMEOUT_MS - 1);
    localparam logic [7:0] THR_MAX = 8'(THR_LOW_MAX);
    localparam logic [RATE_W:0] STEP = (RATE_W + 1)'(SLEW_STEP);

    arm_state_t r_state, w_next;
    logic w_tick, w_ok, w_stay_armed, r_rx_lost;
    logic [HW-1:0] r_hold;
    logic [WW-1:0] r_wd;
    logic [1:0] r_fault;
    logic [RATE_W-1:0] w_in [NUM_MOTORS];
    logic [RATE_W-1:0] w_out [NUM_MOTORS];

    motor_arm_sequencer_ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .sys_clk(sys_clk),
        .resetn (resetn),
        .o_tick (w_tick)
    );

    // rx_lost starts set so nothing arms before the receiver has been heard from
    always_ff @(posedge sys_clk)
        if (!resetn) begin
            r_wd <= '0;
            r_rx_lost <= 1'b1;
        end else if (rx_update) begin
            r_wd <= '0;
            r_rx_lost <= 1'b0;
        end else if (w_tick && r_wd != WD_MAX) begin
            r_wd <= r_wd + 1'b1;
            r_rx_lost <= r_rx_lost | (r_wd == WD_LAST);
        end

    assign w_ok = arm_switch && (throttle_val <= THR_MAX) && imu_good && !r_rx_lost;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_DISARMED: if (w_ok) w_next = ST_ARMING;
            ST_ARMING:
                if (!w_ok) w_next = ST_DISARMED;
                else if (w_tick && r_hold == HOLD_LAST) w_next = ST_ARMED;
            ST_ARMED:
                if (!imu_good || r_rx_lost) w_next = ST_FAILSAFE;
                else if (!arm_switch) w_next = ST_DISARMED;
            default: if (!arm_switch && imu_good && !r_rx_lost) w_next = ST_DISARMED;
        endcase
    end

    always_ff @(posedge sys_clk)
        if (!resetn) begin
            r_state <= ST_DISARMED;
            r_hold <= '0;
            r_fault <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != ST_ARMING) r_hold <= '0;
            else if (w_tick) r_hold <= r_hold + 1'b1;
            if (r_state == ST_ARMED && w_next == ST_FAILSAFE) r_fault <= {r_rx_lost, !imu_good};
            else if (r_state == ST_FAILSAFE && w_next == ST_DISARMED) r_fault <= '0;
        end

    // outputs only pass while staying ARMED, so any exit zeroes them on the next cycle
    assign w_stay_armed = r_state == ST_ARMED && w_next == ST_ARMED;
    assign w_in = '{motor_1_rate_in, motor_2_rate_in, motor_3_rate_in, motor_4_rate_in};

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
        logic [RATE_W:0] w_gap, w_rise;
        logic [RATE_W-1:0] w_slew, r_out;
        assign w_gap = {1'b0, w_in[i]} - {1'b0, r_out};
        assign w_rise = (w_gap > STEP) ? STEP : w_gap;
        assign w_slew = (w_in[i] <= r_out) ? w_in[i] : w_tick ? RATE_W'({1'b0, r_out} + w_rise) : r_out;
        always_ff @(posedge sys_clk)
            if (!resetn) r_out <= '0;
            else r_out <= !w_stay_armed ? '0 : SLEW_EN ? w_slew : w_in[i];
        assign w_out[i] = r_out;
    end

    assign motor_1_rate_out = w_out[0];
    assign motor_2_rate_out = w_out[1];
    assign motor_3_rate_out = w_out[2];
    assign motor_4_rate_out = w_out[3];
    assign armed = r_state == ST_ARMED;
    assign state_out = r_state;
    assign fault_flags = r_fault;
endmodule
